onehot_code_sequencer: RTL and testbench
========================================

Name: onehot_code_sequencer

Overview:
Downstream consumer of the 4-bit casez decoder output (out[3:0]). It checks each incoming code for one-hot legality, re-encodes legal codes to a 2-bit index tagged with a sequence number, and buffers them in a 2-entry FIFO behind a valid/ready handshake. Illegal codes are dropped and counted. An optional per-index hit-statistics bank can be compiled in.

Parameters:
CNT_W, 8, width of the sequence number, the error counter and each hit counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous active-high reset.
in_valid  input  1  a code is presented on in_code.
in_ready  output  1  block can accept a code this cycle.
in_code  input  4  code from the decoder (decoder out[3:0]).
clr  input  1  synchronous clear of error and statistics state only.
out_valid  output  1  FIFO head is valid.
out_ready  input  1  downstream accepts the head this cycle.
out_idx  output  2  re-encoded index of the FIFO head.
out_seq  output  CNT_W  sequence number of the FIFO head.
err_sticky  output  1  set on any dropped illegal code.
err_count  output  CNT_W  saturating count of dropped illegal codes.
hit_cnt  output  4*CNT_W  per-index hit counters, index i at bits [i*CNT_W +: CNT_W]. Present only with CODE_STATS_EN.

Behaviour:
- Reset (rst=1 at a clock edge): FIFO empty; out_valid=0, out_idx=0, out_seq=0; internal seq counter=0; err_sticky=0; err_count=0; hit_cnt=0. rst overrides clr and all handshakes, including mid-transfer: buffered entries are discarded.
- Accept: in_valid && in_ready at the clock edge.
- in_ready = (FIFO count < 2). It is combinational from the count only and never depends on out_ready, so there is no pass-through when full.
- Legality: exactly one bit set. 0001 maps to 0, 0010 to 1, 0100 to 2, 1000 to 3.
  - 0000 and any multi-hot value are illegal.
  - An accepted illegal code is dropped without being enqueued: err_sticky<=1, err_count increments and saturates at 2^CNT_W-1, and the seq counter does not advance.
- An accepted legal code enqueues {idx, seq}, then seq<=seq+1, wrapping modulo 2^CNT_W.
- Latency: a legal code accepted at edge N is visible on out_idx/out_seq with out_valid=1 after edge N, if the FIFO was empty.
- Pop: out_valid && out_ready at the edge. The head advances in FIFO order. out_idx/out_seq are held stable while out_valid=1 and out_ready=0.
- FIFO count states:
  - EMPTY: a legal push moves to ONE.
  - ONE: push only moves to FULL. Pop only moves to EMPTY. Push and pop together stay in ONE with the new entry at the head. An illegal push with a pop moves to EMPTY.
  - FULL: pop moves to ONE. No push is possible.
- out_valid=0 in EMPTY. out_idx/out_seq then hold their last value, or 0 after reset.
- clr=1 (no rst): err_sticky<=0, err_count<=0, hit_cnt<=0. FIFO and seq are unaffected.
  - If clr coincides with an illegal accept, clr wins and the counter ends at 0.
  - If clr coincides with a legal accept, hit_cnt ends at 0.
- Inputs carrying X/Z are outside scope. The bench drives only 0/1 on in_code when in_valid=1.

Optional Feature:
CODE_STATS_EN
- Defined: hit_cnt port and four CNT_W saturating counters exist. Counter idx increments on each legal accept of that idx, saturates at 2^CNT_W-1, and is cleared by rst/clr.
- Undefined: hit_cnt port and counters are absent. All other behaviour is identical.

Test Plan:
- Reset, then in_code=0100 valid one cycle, out_ready=1 -> next cycle out_valid=1, out_idx=2, out_seq=0; following cycle out_valid=0.
- out_ready=0; push 0001, 1000, then 0010 -> first two accepted (seq 0,1). in_ready=0 on the third cycle, and 0010 is held. Raise out_ready -> pops idx 0 then 3, then 0010 is accepted as idx 1, seq 2.
- Push 0000, 0110, 1111 -> nothing enqueued, err_count=3, err_sticky=1, seq unchanged. Pulse clr -> err_count=0, err_sticky=0.
- CNT_W=2: push 5 legal codes -> out_seq sequence 0,1,2,3,0. Push 4 illegal codes -> err_count saturates at 3.
- FIFO at count 1 with simultaneous legal push and pop -> count stays 1 and the new entry is at the head. rst asserted with 2 entries buffered -> out_valid=0 next cycle, err/seq=0.
- With CODE_STATS_EN: push 0001 x3 and 1000 x1 -> hit_cnt idx0=3, idx3=1, others 0.

Source files
------------

// File: rtl/onehot_code_sequencer.sv
// onehot_code_sequencer
// Takes 4-bit codes from the casez decoder and checks each one for one-hot
// legality. A legal code becomes a 2-bit index tagged with a sequence
// number and goes into a 2-entry FIFO behind a valid/ready handshake.
// An illegal code is dropped and counted.
//
// Optional feature macro: CODE_STATS_EN
//   When defined, the block has four saturating per-index hit counters and
//   the hit_cnt port.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (overrides clr and handshakes)
//   in_valid   a code is presented on in_code
//   in_ready   the block can accept a code (FIFO count < 2)
//   in_code    4-bit code from the decoder
//   clr        synchronous clear of error/statistics state only
//   out_valid  FIFO head is valid
//   out_ready  downstream accepts the head
//   out_idx    re-encoded index of the FIFO head
//   out_seq    sequence number of the FIFO head
//   err_sticky set by any dropped illegal code
//   err_count  saturating count of dropped illegal codes
//   hit_cnt    per-index hit counters, index i at [i*CNT_W +: CNT_W]
//              (CODE_STATS_EN only)

module onehot_code_sequencer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_code,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_idx,
    output logic [CNT_W-1:0] out_seq,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count
`ifdef CODE_STATS_EN
    ,
    output logic [4*CNT_W-1:0] hit_cnt
`endif
);

    localparam int unsigned IDX_W = 2;
    localparam int unsigned NUM_IDX = 4;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [CNT_W-1:0] seq;
    } entry_t;

    // FIFO occupancy states
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    entry_t           head;
    entry_t           head_nxt;
    entry_t           tail;
    entry_t           tail_nxt;
    logic [CNT_W-1:0] seq;
    logic             valid_q;
    logic             ready_q;
    logic             sticky_q;
    logic [CNT_W-1:0] err_q;

    logic             legal;
    logic [IDX_W-1:0] code_idx;
    logic             accept;
    logic             push;
    logic             drop;
    logic             pop;
    entry_t           new_entry;

    // One-hot legality check and index encoding
    always_comb begin
        legal    = 1'b0;
        code_idx = '0;
        case (in_code)
            4'b0001: begin legal = 1'b1; code_idx = 2'd0; end
            4'b0010: begin legal = 1'b1; code_idx = 2'd1; end
            4'b0100: begin legal = 1'b1; code_idx = 2'd2; end
            4'b1000: begin legal = 1'b1; code_idx = 2'd3; end
            default: begin legal = 1'b0; code_idx = '0;   end
        endcase
    end

    // Handshake qualifiers
    always_comb begin
        accept        = in_valid && ready_q;
        push          = accept && legal;
        drop          = accept && !legal;
        pop           = valid_q && out_ready;
        new_entry.idx = code_idx;
        new_entry.seq = seq;
    end

    // State register plus FIFO storage and registered status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_EMPTY;
            head    <= '0;
            tail    <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state   <= state_nxt;
            head    <= head_nxt;
            tail    <= tail_nxt;
            valid_q <= (state_nxt != S_EMPTY);
            ready_q <= (state_nxt != S_FULL);
        end
    end

    // Next-state and FIFO data movement
    always_comb begin
        state_nxt = state;
        head_nxt  = head;
        tail_nxt  = tail;
        case (state)
            S_EMPTY: begin
                if (push) begin
                    state_nxt = S_ONE;
                    head_nxt  = new_entry;
                end
            end
            S_ONE: begin
                if (push && pop) begin
                    // old head leaves, the new entry becomes the head
                    state_nxt = S_ONE;
                    head_nxt  = new_entry;
                end else if (push) begin
                    state_nxt = S_FULL;
                    tail_nxt  = new_entry;
                end else if (pop) begin
                    // head keeps its last value while empty
                    state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                if (pop) begin
                    state_nxt = S_ONE;
                    head_nxt  = tail;
                end
            end
            default: begin
                state_nxt = S_EMPTY;
            end
        endcase
    end

    // Sequence number: advances only on legal accepts, wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            seq <= '0;
        end else if (push) begin
            seq <= seq + 1'b1;
        end
    end

    // Error tracking; clr beats a simultaneous drop
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sticky_q <= 1'b0;
            err_q    <= '0;
        end else if (drop) begin
            sticky_q <= 1'b1;
            if (err_q != {CNT_W{1'b1}}) begin
                err_q <= err_q + 1'b1;
            end
        end
    end

`ifdef CODE_STATS_EN
    logic [CNT_W-1:0] hit_q [NUM_IDX];

    // Per-index saturating hit counters; clr beats a simultaneous hit
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NUM_IDX); i++) begin
            if (rst || clr) begin
                hit_q[i] <= '0;
            end else if (push && (code_idx == IDX_W'(i)) &&
                         (hit_q[i] != {CNT_W{1'b1}})) begin
                hit_q[i] <= hit_q[i] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < int'(NUM_IDX); g++) begin : g_hit
        assign hit_cnt[g*CNT_W +: CNT_W] = hit_q[g];
    end
`endif

    assign in_ready   = ready_q;
    assign out_valid  = valid_q;
    assign out_idx    = head.idx;
    assign out_seq    = head.seq;
    assign err_sticky = sticky_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_onehot_code_sequencer.sv
// Bench for onehot_code_sequencer: table-driven vectors on a CNT_W=8
// instance plus hand sequences on a CNT_W=2 instance (wrap/saturation)
// and, with CODE_STATS_EN, the hit counters.

module tb_onehot_code_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // CNT_W = 8 instance
    logic       rst, in_valid, in_ready, clr, out_valid, out_ready;
    logic [3:0] in_code;
    logic [1:0] out_idx;
    logic [7:0] out_seq, err_count;
    logic       err_sticky;
`ifdef CODE_STATS_EN
    logic [31:0] hit_cnt;
`endif

    // CNT_W = 2 instance
    logic       rst2, in_valid2, in_ready2, clr2, out_valid2, out_ready2;
    logic [3:0] in_code2;
    logic [1:0] out_idx2;
    logic [1:0] out_seq2, err_count2;
    logic       err_sticky2;
`ifdef CODE_STATS_EN
    logic [7:0] hit_cnt2;
`endif

    onehot_code_sequencer #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .clr(clr), .out_valid(out_valid),
        .out_ready(out_ready), .out_idx(out_idx), .out_seq(out_seq),
        .err_sticky(err_sticky), .err_count(err_count)
`ifdef CODE_STATS_EN
        , .hit_cnt(hit_cnt)
`endif
    );

    onehot_code_sequencer #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_code(in_code2), .clr(clr2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_idx(out_idx2), .out_seq(out_seq2),
        .err_sticky(err_sticky2), .err_count(err_count2)
`ifdef CODE_STATS_EN
        , .hit_cnt(hit_cnt2)
`endif
    );

    typedef struct {
        logic       rst;
        logic       iv;
        logic [3:0] code;
        logic       ordy;
        logic       clr;
        logic       e_ir;
        logic       e_ov;
        logic [1:0] e_idx;
        logic [7:0] e_seq;
        logic       e_st;
        logic [7:0] e_ec;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(logic r, logic iv, logic [3:0] code, logic ordy,
                                logic c, logic e_ir, logic e_ov, logic [1:0] e_idx,
                                logic [7:0] e_seq, logic e_st, logic [7:0] e_ec);
        vec_t v;
        v.rst = r; v.iv = iv; v.code = code; v.ordy = ordy; v.clr = c;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_idx = e_idx; v.e_seq = e_seq;
        v.e_st = e_st; v.e_ec = e_ec;
        return v;
    endfunction

    task automatic chk(input string name, input int step, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, step, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_code = 4'b0; clr = 1'b0; out_ready = 1'b0;
        rst2 = 1'b1; in_valid2 = 1'b0; in_code2 = 4'b0; clr2 = 1'b0; out_ready2 = 1'b0;

        //                 rst iv code     ordy clr  ir  ov  idx  seq  st  ec
        vecs[0]  = mk(1, 0, 4'b0000, 0, 0,  1,  0,  0,   0,   0,  0);
        vecs[1]  = mk(0, 1, 4'b0100, 1, 0,  1,  1,  2,   0,   0,  0);
        vecs[2]  = mk(0, 0, 4'b0000, 1, 0,  1,  0,  2,   0,   0,  0);
        vecs[3]  = mk(0, 1, 4'b0001, 0, 0,  1,  1,  0,   1,   0,  0);
        vecs[4]  = mk(0, 1, 4'b1000, 0, 0,  0,  1,  0,   1,   0,  0);
        vecs[5]  = mk(0, 1, 4'b0010, 0, 0,  0,  1,  0,   1,   0,  0);
        vecs[6]  = mk(0, 1, 4'b0010, 1, 0,  1,  1,  3,   2,   0,  0);
        vecs[7]  = mk(0, 1, 4'b0010, 1, 0,  1,  1,  1,   3,   0,  0);
        vecs[8]  = mk(0, 0, 4'b0000, 1, 0,  1,  0,  1,   3,   0,  0);
        vecs[9]  = mk(0, 1, 4'b0000, 1, 0,  1,  0,  1,   3,   1,  1);
        vecs[10] = mk(0, 1, 4'b0110, 1, 0,  1,  0,  1,   3,   1,  2);
        vecs[11] = mk(0, 1, 4'b1111, 1, 0,  1,  0,  1,   3,   1,  3);
        vecs[12] = mk(0, 1, 4'b0100, 0, 0,  1,  1,  2,   4,   1,  3);
        vecs[13] = mk(0, 0, 4'b0000, 0, 1,  1,  1,  2,   4,   0,  0);
        vecs[14] = mk(0, 1, 4'b0001, 0, 0,  0,  1,  2,   4,   0,  0);
        vecs[15] = mk(1, 1, 4'b0001, 1, 0,  1,  0,  0,   0,   0,  0);
        vecs[16] = mk(0, 1, 4'b1000, 0, 0,  1,  1,  3,   0,   0,  0);
        vecs[17] = mk(0, 1, 4'b0011, 0, 1,  1,  1,  3,   0,   0,  0);
        vecs[18] = mk(0, 1, 4'b0101, 1, 0,  1,  0,  3,   0,   1,  1);
        vecs[19] = mk(0, 1, 4'b0010, 0, 1,  1,  1,  1,   1,   0,  0);

        // Table-driven vectors on the CNT_W=8 instance
        for (int i = 0; i < NV; i++) begin
            rst = vecs[i].rst; in_valid = vecs[i].iv; in_code = vecs[i].code;
            out_ready = vecs[i].ordy; clr = vecs[i].clr;
            tick();
            chk("in_ready",   i, int'(in_ready),   int'(vecs[i].e_ir));
            chk("out_valid",  i, int'(out_valid),  int'(vecs[i].e_ov));
            chk("out_idx",    i, int'(out_idx),    int'(vecs[i].e_idx));
            chk("out_seq",    i, int'(out_seq),    int'(vecs[i].e_seq));
            chk("err_sticky", i, int'(err_sticky), int'(vecs[i].e_st));
            chk("err_count",  i, int'(err_count),  int'(vecs[i].e_ec));
        end
        in_valid = 1'b0; clr = 1'b0; out_ready = 1'b0;

        // CNT_W=2: sequence wrap through push+pop in the one-entry state
        tick();
        rst2 = 1'b0; out_ready2 = 1'b1; in_valid2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic [3:0] c;
            c = 4'b0001 << (i % 4);
            in_code2 = c;
            tick();
            chk("w2_out_valid", i, int'(out_valid2), 1);
            chk("w2_out_idx",   i, int'(out_idx2),   i % 4);
            chk("w2_out_seq",   i, int'(out_seq2),   i % 4);
        end
        // CNT_W=2: error counter saturation
        for (int i = 0; i < 4; i++) begin
            logic [3:0] bad [4];
            bad[0] = 4'b0000; bad[1] = 4'b1100; bad[2] = 4'b0111; bad[3] = 4'b1111;
            in_code2 = bad[i];
            tick();
            chk("w2_err_count",  i, int'(err_count2),  (i < 3) ? i + 1 : 3);
            chk("w2_err_sticky", i, int'(err_sticky2), 1);
        end
        chk("w2_empty_after_drop", 0, int'(out_valid2), 0);
        in_valid2 = 1'b0; clr2 = 1'b1;
        tick();
        chk("w2_clr_count",  0, int'(err_count2),  0);
        chk("w2_clr_sticky", 0, int'(err_sticky2), 0);
        chk("w2_seq_kept",   0, int'(out_seq2),    0);
        clr2 = 1'b0;

`ifdef CODE_STATS_EN
        // Hit counters: 0001 x3, 1000 x1, then clear
        rst = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_code = (i < 3) ? 4'b0001 : 4'b1000;
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("hit0", 0, int'(hit_cnt[7:0]),   3);
        chk("hit1", 0, int'(hit_cnt[15:8]),  0);
        chk("hit2", 0, int'(hit_cnt[23:16]), 0);
        chk("hit3", 0, int'(hit_cnt[31:24]), 1);
        // clr coinciding with a legal accept leaves the counters at zero
        in_valid = 1'b1; in_code = 4'b0100; clr = 1'b1;
        tick();
        in_valid = 1'b0; clr = 1'b0;
        chk("hit_clr", 0, int'(hit_cnt), 0);
        chk("hit_clr_seq", 0, int'(out_seq), 4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
